// File: rtl/pck_memory_map.sv
// Word offsets of the PWM capture registers inside its 1 KiB window.
// Offsets are word addresses, compared against i_addr[9:2].
// Anything not listed here is undecoded and withdraws the ack.
package pck_memory_map;

  localparam logic [7:0] PWMCAP_CONFIG_OFFSET = 8'h00;
  localparam logic [7:0] PWMCAP_STATUS_OFFSET = 8'h01;
  localparam logic [7:0] PWMCAP_PERIOD_OFFSET = 8'h02;
  localparam logic [7:0] PWMCAP_HIGH_OFFSET   = 8'h03;

endpackage

// File: rtl/pck_registers.sv
// Register layouts and measurement FSM encoding for the PWM capture block.
// The state encoding is visible to software through STATUS[5:4].
// Pure type/function package, no timing involved.
package pck_registers;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_HIGH      = 2'd2,
    ST_LOW       = 2'd3
  } pwmcap_state_e;

  // CONFIG[7:0]
  typedef struct packed {
    logic [3:0] scale;
    logic       irq_en;
    logic       invert;
    logic       oneshot;
    logic       en;
  } pwmcap_config_t;

  // STATUS[2:0], all write-one-to-clear
  typedef struct packed {
    logic overrun;
    logic overflow;
    logic valid;
  } pwmcap_status_t;

  function automatic logic [31:0] pwmcap_status_word(input pwmcap_status_t sts,
                                                     input pwmcap_state_e  st);
    return {26'd0, st, 1'b0, sts};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Purpose: bring the async PWM pin into i_clk and flag its (optionally inverted) edges.
// Latency: edge pulses are high in the 3rd cycle after the pin changes.
// Backpressure: none, free-running one-cycle pulses.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  input  logic i_invert,
  output logic o_rise,
  output logic o_fall
);

  logic sync1;
  logic sync2;
  logic prev;
  logic lvl;
  logic lvl_prev;

  // Two-flop synchronizer followed by the edge-detect history flop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= i_async;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Invert applied to both taps so toggling it never fabricates an edge
  assign lvl      = sync2 ^ i_invert;
  assign lvl_prev = prev ^ i_invert;
  assign o_rise   = lvl & ~lvl_prev;
  assign o_fall   = ~lvl & lvl_prev;

endmodule

// File: rtl/perif_pwm_capture.sv
// Purpose: measure period and high time of an async PWM input, register-mapped.
// Latency: read data one cycle after i_rd_en; edges seen 3 cycles after the pin moves.
// Backpressure: never busy; ack withdrawn only after an access to an undecoded address.
module perif_pwm_capture
  import pck_memory_map::*, pck_registers::*;
#(
  parameter int p_cnt_width = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:2]  i_addr,
  input  logic [3:0]  i_be,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic        i_rd_en,
  output logic [31:0] o_rd_data,
  output logic        o_busy,
  output logic        o_ack,
  input  logic        i_pwm_in,
  output logic        o_cap_irq
);

  localparam logic [p_cnt_width-1:0] CNT_MAX = '1;
  localparam logic [p_cnt_width-1:0] CNT_ONE = {{(p_cnt_width-1){1'b0}}, 1'b1};

  pwmcap_config_t        cfg_q;
  pwmcap_status_t        sts_q;
  pwmcap_state_e         state_q;
  pwmcap_state_e         state_d;
  logic [p_cnt_width-1:0] per_cnt;
  logic [p_cnt_width-1:0] hi_cnt;
  logic [p_cnt_width-1:0] hi_shadow;
  logic [p_cnt_width-1:0] period_q;
  logic [p_cnt_width-1:0] high_q;
  logic [p_cnt_width-1:0] tick_w;
  logic [14:0]            pre_cnt;
  logic [14:0]            pre_top;
  logic                   tick;
  logic                   rise;
  logic                   fall;
  logic                   cap;
  logic                   ovf;
  logic                   sh_ld;
  logic                   clr_cnt;
  logic                   hit_cfg;
  logic                   hit_sts;
  logic                   hit_per;
  logic                   hit_high;
  logic                   addr_ok;
  logic                   wr_cfg;
  logic                   wr_sts;
  logic                   wr_ack_q;
  logic                   rd_ack_q;
  logic [31:0]            rd_mux;
  logic                   unused_bus_bits;

  assign unused_bus_bits = ^{i_be[3:1], i_wr_data[31:8]};

  sync_edge_det u_sync (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_async  (i_pwm_in),
    .i_invert (cfg_q.invert),
    .o_rise   (rise),
    .o_fall   (fall)
  );

  assign hit_cfg  = (i_addr == PWMCAP_CONFIG_OFFSET);
  assign hit_sts  = (i_addr == PWMCAP_STATUS_OFFSET);
  assign hit_per  = (i_addr == PWMCAP_PERIOD_OFFSET);
  assign hit_high = (i_addr == PWMCAP_HIGH_OFFSET);
  assign addr_ok  = hit_cfg | hit_sts | hit_per | hit_high;
  assign wr_cfg   = i_wr_en & hit_cfg & i_be[0];
  assign wr_sts   = i_wr_en & hit_sts & i_be[0];

  // Prescaler wraps every 2^scale cycles; tick marks the last cycle of each window
  assign pre_top = 15'((32'd1 << cfg_q.scale) - 32'd1);
  assign tick    = (pre_cnt == pre_top);
  assign tick_w  = {{(p_cnt_width-1){1'b0}}, tick};

  // Prescaler restarts on every rising edge so windows align to the measurement start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_cnt <= '0;
    end else if (rise || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 15'd1;
    end
  end

  // Measurement FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus capture/abort strobes; a saturated period counter beats any edge
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    ovf     = 1'b0;
    sh_ld   = 1'b0;
    if (!cfg_q.en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_RISE;
        ST_WAIT_RISE: begin
          if (rise) state_d = ST_HIGH;
        end
        ST_HIGH: begin
          if (per_cnt == CNT_MAX) begin
            ovf     = 1'b1;
            state_d = ST_WAIT_RISE;
          end else if (fall) begin
            sh_ld   = 1'b1;
            state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (per_cnt == CNT_MAX) begin
            ovf     = 1'b1;
            state_d = ST_WAIT_RISE;
          end else if (rise) begin
            cap     = 1'b1;
            state_d = cfg_q.oneshot ? ST_IDLE : ST_HIGH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign clr_cnt = ((state_q != ST_HIGH) && (state_q != ST_LOW)) || cap || ovf || !cfg_q.en;

  // Period counter runs through HIGH and LOW, high counter only through HIGH
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (clr_cnt) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (tick) begin
      per_cnt <= per_cnt + CNT_ONE;
      if (state_q == ST_HIGH) hi_cnt <= hi_cnt + CNT_ONE;
    end
  end

  // Shadow and result registers; the edge-cycle tick is folded in so counts are floor(dt/2^scale)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_shadow <= '0;
      period_q  <= '0;
      high_q    <= '0;
    end else begin
      if (sh_ld) hi_shadow <= hi_cnt + tick_w;
      if (cap) begin
        period_q <= per_cnt + tick_w;
        high_q   <= hi_shadow;
      end
    end
  end

  // CONFIG write; oneshot completion drops en after any software write in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_q <= '0;
    end else begin
      if (wr_cfg) cfg_q <= pwmcap_config_t'(i_wr_data[7:0]);
      if (cap && cfg_q.oneshot) cfg_q.en <= 1'b0;
    end
  end

  // STATUS sticky bits: hardware set wins over a coincident write-one-to-clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sts_q <= '0;
    end else begin
      if (cap)                         sts_q.valid <= 1'b1;
      else if (wr_sts && i_wr_data[0]) sts_q.valid <= 1'b0;
      if (ovf)                         sts_q.overflow <= 1'b1;
      else if (wr_sts && i_wr_data[1]) sts_q.overflow <= 1'b0;
      if (cap && sts_q.valid)          sts_q.overrun <= 1'b1;
      else if (wr_sts && i_wr_data[2]) sts_q.overrun <= 1'b0;
    end
  end

  // Read multiplexer, results zero-extended
  always_comb begin
    rd_mux = '0;
    case (i_addr)
      PWMCAP_CONFIG_OFFSET: rd_mux = {24'd0, cfg_q};
      PWMCAP_STATUS_OFFSET: rd_mux = pwmcap_status_word(sts_q, state_q);
      PWMCAP_PERIOD_OFFSET: rd_mux = 32'(period_q);
      PWMCAP_HIGH_OFFSET:   rd_mux = 32'(high_q);
      default:              rd_mux = '0;
    endcase
  end

  // Registered read data and ack flags; an undecoded access withdraws the next ack
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      if (i_rd_en) o_rd_data <= rd_mux;
      wr_ack_q <= !(i_wr_en && !addr_ok);
      rd_ack_q <= !(i_rd_en && !addr_ok);
    end
  end

  assign o_ack     = (i_wr_en & wr_ack_q) | (i_rd_en & rd_ack_q);
  assign o_busy    = 1'b0;
  assign o_cap_irq = cfg_q.irq_en & (sts_q.valid | sts_q.overflow);

endmodule

// File: tb/tb_perif_pwm_capture.sv
module tb_perif_pwm_capture;
  import pck_memory_map::*;

  localparam int S_IDLE = 0;
  localparam int S_WAIT = 1;
  localparam int S_HIGH = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic [3:0]  be;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_data;
  logic        pwm;
  logic [31:0] rd_data, rd_data8;
  logic        busy, busy8, ack, ack8, irq, irq8;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_t[$];
  int fall_t[$];
  logic cur_lvl;
  logic inv;
  logic last_ack;
  logic [31:0] rv, rv8;

  perif_pwm_capture #(.p_cnt_width(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_be(be), .i_wr_en(wr_en),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .o_rd_data(rd_data), .o_busy(busy),
    .o_ack(ack), .i_pwm_in(pwm), .o_cap_irq(irq)
  );

  perif_pwm_capture #(.p_cnt_width(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_be(be), .i_wr_en(wr_en),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .o_rd_data(rd_data8), .o_busy(busy8),
    .o_ack(ack8), .i_pwm_in(pwm), .o_cap_irq(irq8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_status(input bit v, input bit ovf, input bit ovr, input int st);
    return (32'(st) << 4) | {29'd0, ovr, ovf, v};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
    addr = a; be = b; wr_data = d; wr_en = 1'b1;
    #1 last_ack = ack;
    @(negedge clk);
    wr_en = 1'b0; be = 4'h0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic [31:0] d8);
    addr = a; rd_en = 1'b1;
    #1 last_ack = ack;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data; d8 = rd_data8;
  endtask

  // Logical PWM level; edge times recorded in clock cycles for the reference model
  task automatic set_lvl(input logic v);
    if (v && !cur_lvl) rise_t.push_back(cyc);
    if (!v && cur_lvl) fall_t.push_back(cyc);
    cur_lvl = v;
    pwm = v ^ inv;
  endtask

  task automatic run_meas(input logic [7:0] cfg, input int h, input int l, input int np);
    inv = cfg[2];
    cur_lvl = 1'b0;
    pwm = inv;
    cycles(3);
    bus_write(PWMCAP_CONFIG_OFFSET, 4'h1, 32'h0);
    bus_write(PWMCAP_STATUS_OFFSET, 4'h1, 32'h7);
    rise_t.delete();
    fall_t.delete();
    bus_write(PWMCAP_CONFIG_OFFSET, 4'h1, {24'd0, cfg});
    cycles(4);
    repeat (np) begin
      set_lvl(1'b1); cycles(h);
      set_lvl(1'b0); cycles(l);
    end
    set_lvl(1'b1);
    cycles(6);
  endtask

  // Expected results from edge timestamps: the last captured period is rise[k]-rise[k-1]
  task automatic check_meas(input string tag, input logic [7:0] cfg);
    int s, n_cap, k, e_per, e_hi;
    bit os;
    s = int'(cfg[7:4]);
    os = cfg[1];
    n_cap = os ? 1 : rise_t.size() - 1;
    k = n_cap;
    e_per = (rise_t[k] - rise_t[k-1]) >> s;
    e_hi  = (fall_t[k-1] - rise_t[k-1]) >> s;
    bus_read(PWMCAP_PERIOD_OFFSET, rv, rv8);
    check_val({tag, ".period"}, rv, 32'(e_per));
    bus_read(PWMCAP_HIGH_OFFSET, rv, rv8);
    check_val({tag, ".high"}, rv, 32'(e_hi));
    bus_read(PWMCAP_STATUS_OFFSET, rv, rv8);
    check_val({tag, ".status"}, rv, mk_status(1'b1, 1'b0, n_cap > 1, os ? S_IDLE : S_HIGH));
    bus_read(PWMCAP_CONFIG_OFFSET, rv, rv8);
    check_val({tag, ".config"}, rv, {24'd0, os ? (cfg & 8'hFE) : cfg});
    check_val({tag, ".irq"}, {31'd0, irq}, {31'd0, cfg[3]});
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; be = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    pwm = 1'b0; inv = 1'b0; cur_lvl = 1'b0; last_ack = 1'b0;

    // Reset state
    #2;
    check_val("rst.rd_data", rd_data, 32'h0);
    check_val("rst.ack", {31'd0, ack}, 32'h0);
    check_val("rst.irq", {31'd0, irq}, 32'h0);
    check_val("rst.busy", {30'd0, busy, busy8}, 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    bus_read(PWMCAP_CONFIG_OFFSET, rv, rv8);  check_val("rst.config", rv, 32'h0);
    bus_read(PWMCAP_STATUS_OFFSET, rv, rv8);  check_val("rst.status", rv, 32'h0);
    bus_read(PWMCAP_PERIOD_OFFSET, rv, rv8);  check_val("rst.period", rv, 32'h0);
    bus_read(PWMCAP_HIGH_OFFSET, rv, rv8);    check_val("rst.high", rv, 32'h0);

    // 8-bit counters: long high phase saturates and aborts
    bus_write(PWMCAP_CONFIG_OFFSET, 4'h1, 32'h09);
    cycles(4);
    set_lvl(1'b1);
    cycles(300);
    bus_read(PWMCAP_STATUS_OFFSET, rv, rv8);
    check_val("ovf.status8", rv8, mk_status(1'b0, 1'b1, 1'b0, S_WAIT));
    check_val("ovf.status16", rv, mk_status(1'b0, 1'b0, 1'b0, S_HIGH));
    bus_read(PWMCAP_PERIOD_OFFSET, rv, rv8);  check_val("ovf.period8", rv8, 32'h0);
    bus_read(PWMCAP_HIGH_OFFSET, rv, rv8);    check_val("ovf.high8", rv8, 32'h0);
    check_val("ovf.irq8", {31'd0, irq8}, 32'h1);
    set_lvl(1'b0);
    cycles(5);

    // 30 high / 70 low, scale 0
    run_meas(8'h09, 30, 70, 2);
    bus_read(PWMCAP_PERIOD_OFFSET, rv, rv8);  check_val("s0.period", rv, 32'd100);
    bus_read(PWMCAP_HIGH_OFFSET, rv, rv8);    check_val("s0.high", rv, 32'd30);
    bus_read(PWMCAP_STATUS_OFFSET, rv, rv8);  check_val("s0.status", rv, mk_status(1'b1, 1'b0, 1'b1, S_HIGH));
    check_val("s0.irq", {31'd0, irq}, 32'h1);
    bus_read(PWMCAP_STATUS_OFFSET, rv, rv8);  check_val("s0.status_reread", rv, mk_status(1'b1, 1'b0, 1'b1, S_HIGH));

    // Same waveform, scale 2
    run_meas(8'h29, 30, 70, 2);
    bus_read(PWMCAP_PERIOD_OFFSET, rv, rv8);  check_val("s2.period", rv, 32'd25);
    bus_read(PWMCAP_HIGH_OFFSET, rv, rv8);    check_val("s2.high", rv, 32'd7);

    // Byte enables, read-only writes, undecoded addresses
    bus_write(PWMCAP_CONFIG_OFFSET, 4'hE, 32'hFFFF_FFFF);
    check_val("be.ack", {31'd0, last_ack}, 32'h1);
    bus_read(PWMCAP_CONFIG_OFFSET, rv, rv8);  check_val("be.config", rv, 32'h29);
    bus_write(PWMCAP_PERIOD_OFFSET, 4'hF, 32'h0000_FFFF);
    check_val("ro.ack", {31'd0, last_ack}, 32'h1);
    bus_read(PWMCAP_PERIOD_OFFSET, rv, rv8);  check_val("ro.period", rv, 32'd25);
    bus_write(8'h10, 4'hF, 32'h1);
    check_val("undec.wr_ack1", {31'd0, last_ack}, 32'h1);
    bus_write(8'h10, 4'hF, 32'h1);
    check_val("undec.wr_ack2", {31'd0, last_ack}, 32'h0);
    cycles(1);
    bus_read(8'h20, rv, rv8);
    check_val("undec.rd_ack1", {31'd0, last_ack}, 32'h1);
    check_val("undec.rd_data", rv, 32'h0);
    bus_read(8'h20, rv, rv8);
    check_val("undec.rd_ack2", {31'd0, last_ack}, 32'h0);
    cycles(1);
    bus_read(PWMCAP_CONFIG_OFFSET, rv, rv8);
    check_val("undec.rd_ack3", {31'd0, last_ack}, 32'h1);

    // Oneshot over three periods: single result, en dropped, later edges ignored
    run_meas(8'h03, 30, 70, 3);
    check_meas("oneshot", 8'h03);

    // en cleared while HIGH, then W1C of valid coincident with a capture
    run_meas(8'h01, 30, 70, 1);
    bus_write(PWMCAP_CONFIG_OFFSET, 4'h1, 32'h0);
    cycles(1);
    bus_read(PWMCAP_STATUS_OFFSET, rv, rv8);  check_val("endis.status", rv, mk_status(1'b1, 1'b0, 1'b0, S_IDLE));
    bus_read(PWMCAP_PERIOD_OFFSET, rv, rv8);  check_val("endis.period", rv, 32'd100);
    bus_read(PWMCAP_HIGH_OFFSET, rv, rv8);    check_val("endis.high", rv, 32'd30);
    set_lvl(1'b0);
    cycles(10);
    bus_write(PWMCAP_CONFIG_OFFSET, 4'h1, 32'h01);
    cycles(4);
    set_lvl(1'b1); cycles(30);
    set_lvl(1'b0); cycles(70);
    set_lvl(1'b1); cycles(2);
    bus_write(PWMCAP_STATUS_OFFSET, 4'h1, 32'h1);
    cycles(5);
    bus_read(PWMCAP_STATUS_OFFSET, rv, rv8);  check_val("w1c.status", rv, mk_status(1'b1, 1'b0, 1'b1, S_HIGH));

    // Randomised waveforms, scales, inversion, oneshot and irq enable
    for (int it = 0; it < 10; it++) begin
      logic [7:0] cfg;
      int h, l, np;
      cfg = {4'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1};
      h = $urandom_range(60, 4);
      l = $urandom_range(60, 4);
      np = $urandom_range(2, 1);
      run_meas(cfg, h, l, np);
      check_meas($sformatf("rnd%0d", it), cfg);
    end

    // Reset pulsed while LOW discards the measurement
    run_meas(8'h09, 30, 70, 1);
    bus_read(PWMCAP_PERIOD_OFFSET, rv, rv8);
    set_lvl(1'b0);
    cycles(20);
    check_val("rlow.irq_before", {31'd0, irq}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("rlow.rd_data", rd_data, 32'h0);
    check_val("rlow.irq", {30'd0, irq, irq8}, 32'h0);
    cycles(3);
    rst_n = 1'b1;
    repeat (2) begin
      set_lvl(1'b1); cycles(30);
      set_lvl(1'b0); cycles(70);
    end
    set_lvl(1'b1);
    cycles(6);
    bus_read(PWMCAP_STATUS_OFFSET, rv, rv8);  check_val("rlow.status", rv, 32'h0);
    bus_read(PWMCAP_PERIOD_OFFSET, rv, rv8);  check_val("rlow.period", rv, 32'h0);
    bus_read(PWMCAP_CONFIG_OFFSET, rv, rv8);  check_val("rlow.config", rv, 32'h0);
    set_lvl(1'b0);
    cycles(10);
    rise_t.delete();
    fall_t.delete();
    bus_write(PWMCAP_CONFIG_OFFSET, 4'h1, 32'h01);
    cycles(4);
    repeat (2) begin
      set_lvl(1'b1); cycles(30);
      set_lvl(1'b0); cycles(70);
    end
    set_lvl(1'b1);
    cycles(6);
    check_meas("rlow.after_en", 8'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
